// File: rtl/phs_pdr_matcher_pkg.sv
// phs_pdr_matcher_pkg: shared PHS/PDR types and the masked-match helper
// Provides PHS_Struct (120-bit parsed header summary), PDR_Entry {valid, key, mask},
// PDR_Result {hit, rule_idx, phs} and pdr_match() used by the matcher.
package phs_pdr_matcher_pkg;
   typedef struct packed {
      logic [31:0] ipv4_src_addr;
      logic [31:0] ipv4_dst_addr;
      logic [15:0] l4_src_port;
      logic [15:0] l4_dst_port;
      logic [7:0]  ip_proto;
      logic [7:0]  ip_tos;
      logic [7:0]  qfi;
   } PHS_Struct;
   localparam int PHS_W = $bits(PHS_Struct);
   localparam int IDX_MAX_W = 6;
   typedef struct packed {
      logic             valid;
      logic [PHS_W-1:0] key;
      logic [PHS_W-1:0] mask;
   } PDR_Entry;
   typedef struct packed {
      logic                 hit;
      logic [IDX_MAX_W-1:0] rule_idx;
      PHS_Struct            phs;
   } PDR_Result;
   // mask bit 1 means the bit is compared; an all-zero mask is a wildcard
   function automatic logic pdr_match(PHS_Struct p, PDR_Entry e);
      return e.valid && (((p ^ e.key) & e.mask) == '0);
   endfunction
endpackage

// File: rtl/phs_pdr_matcher_if.sv
// phs_pdr_matcher_if: PHS input, table config, result output and statistics bundle
// master: PHS producer / configurator / result consumer; slave: the matcher.
interface phs_pdr_matcher_if
   import phs_pdr_matcher_pkg::*;
#(
   parameter int NUM_RULES = 16,
   parameter int CNT_W = 32
);
   localparam int IDX_W = $clog2(NUM_RULES);
   logic             phs_valid;
   logic             phs_ready;
   PHS_Struct        phs_in;
   logic             cfg_wr_en;
   logic [IDX_W-1:0] cfg_wr_idx;
   PDR_Entry         cfg_wr_entry;
   logic             cfg_clear;
   logic             res_valid;
   logic             res_ready;
   logic             res_hit;
   logic [IDX_W-1:0] res_rule_idx;
   PHS_Struct        res_phs;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;
   modport master (
      output phs_valid, phs_in, cfg_wr_en, cfg_wr_idx, cfg_wr_entry, cfg_clear, res_ready,
      input  phs_ready, res_valid, res_hit, res_rule_idx, res_phs, hit_count, miss_count
   );
   modport slave (
      input  phs_valid, phs_in, cfg_wr_en, cfg_wr_idx, cfg_wr_entry, cfg_clear, res_ready,
      output phs_ready, res_valid, res_hit, res_rule_idx, res_phs, hit_count, miss_count
   );
endinterface

// File: rtl/phs_pdr_matcher_prio_enc.sv
// pdr_prio_enc: combinational lowest-index-first priority encoder
// i_vec: request vector; o_hit: any bit set; o_idx: lowest set index (0 when none).
module pdr_prio_enc #(
   parameter int N = 16,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] i_vec,
   output logic         o_hit,
   output logic [W-1:0] o_idx
);
   always_comb begin
      o_hit = |i_vec;
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) o_idx = i_vec[i] ? W'(i) : o_idx;
   end
endmodule

// File: rtl/phs_pdr_matcher.sv
// phs_pdr_matcher: two-stage masked PDR table lookup, lowest-index match wins
// clk, rst (sync, active-high); bus (slave): PHS in with valid/ready, cfg write/clear,
// result out with valid/ready {hit, rule_idx, phs}, saturating hit/miss counters.
module phs_pdr_matcher
   import phs_pdr_matcher_pkg::*;
#(
   parameter int NUM_RULES = 16,
   parameter int CNT_W = 32
) (
   input logic              clk,
   input logic              rst,
   phs_pdr_matcher_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_RULES);
   PDR_Entry             r_tbl [NUM_RULES];
   logic                 r_v1, r_v2, r_hit;
   logic [NUM_RULES-1:0] r_match, w_match;
   logic [IDX_W-1:0]     r_idx, w_idx;
   PHS_Struct            r_phs1, r_phs2;
   logic [CNT_W-1:0]     r_hit_cnt, r_miss_cnt;
   logic                 w_en1, w_en2, w_hit, w_xfer;
   assign w_en2 = !r_v2 || bus.res_ready;
   assign w_en1 = !r_v1 || w_en2;
   assign w_xfer = r_v2 && bus.res_ready;
   for (genvar i = 0; i < NUM_RULES; i++) begin : g_match
      assign w_match[i] = pdr_match(bus.phs_in, r_tbl[i]);
   end
   pdr_prio_enc #(.N(NUM_RULES), .W(IDX_W)) u_enc (
      .i_vec(r_match),
      .o_hit(w_hit),
      .o_idx(w_idx)
   );
   // out-of-range indices never equal a table slot, so such writes fall away
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_RULES; i++) begin
         if (rst) r_tbl[i] <= '0;
         else if (bus.cfg_wr_en && int'(bus.cfg_wr_idx) == i) r_tbl[i] <= bus.cfg_wr_entry;
         else if (bus.cfg_clear) r_tbl[i].valid <= 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1       <= 1'b0;
         r_v2       <= 1'b0;
         r_match    <= '0;
         r_phs1     <= '0;
         r_hit      <= 1'b0;
         r_idx      <= '0;
         r_phs2     <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_en1) r_v1 <= bus.phs_valid;
         if (w_en1 && bus.phs_valid) begin
            r_match <= w_match;
            r_phs1  <= bus.phs_in;
         end
         if (w_en2) r_v2 <= r_v1;
         if (w_en2 && r_v1) begin
            r_hit  <= w_hit;
            r_idx  <= w_idx;
            r_phs2 <= r_phs1;
         end
         if (w_xfer && r_hit) r_hit_cnt <= r_hit_cnt + CNT_W'(r_hit_cnt != '1);
         if (w_xfer && !r_hit) r_miss_cnt <= r_miss_cnt + CNT_W'(r_miss_cnt != '1);
      end
   end
   assign bus.phs_ready    = w_en1;
   assign bus.res_valid    = r_v2;
   assign bus.res_hit      = r_hit;
   assign bus.res_rule_idx = r_idx;
   assign bus.res_phs      = r_phs2;
   assign bus.hit_count    = r_hit_cnt;
   assign bus.miss_count   = r_miss_cnt;
endmodule

// File: tb/tb_phs_pdr_matcher.sv
// tb_phs_pdr_matcher: randomized scoreboard bench for phs_pdr_matcher
module tb_phs_pdr_matcher;
   import phs_pdr_matcher_pkg::*;
   localparam int NR = 16;
   localparam int CW = 5;
   localparam int IW = $clog2(NR);
   localparam int CMAX = (1 << CW) - 1;
   typedef struct packed {
      logic          hit;
      logic [IW-1:0] idx;
      PHS_Struct     phs;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   phs_pdr_matcher_if #(.NUM_RULES(NR), .CNT_W(CW)) bus ();
   phs_pdr_matcher #(.NUM_RULES(NR), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_bad = 0;
   exp_t sb[$];
   PDR_Entry m_tbl [NR];
   int m_hit = 0;
   int m_miss = 0;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: the first valid rule (ascending index) whose compared bits all agree
   function automatic exp_t ref_lookup(PHS_Struct p);
      exp_t e;
      e.hit = 1'b0;
      e.idx = '0;
      e.phs = p;
      for (int i = 0; i < NR; i++) begin
         if (m_tbl[i].valid && ((p ^ m_tbl[i].key) & m_tbl[i].mask) == '0) begin
            e.hit = 1'b1;
            e.idx = IW'(i);
            return e;
         end
      end
      return e;
   endfunction

   function automatic PHS_Struct rnd_phs();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[119:0];
   endfunction

   function automatic PDR_Entry mk(logic v, PHS_Struct k, PHS_Struct m);
      PDR_Entry e;
      e.valid = v;
      e.key = k;
      e.mask = m;
      return e;
   endfunction

   function automatic PDR_Entry rnd_entry();
      PHS_Struct m;
      m = '0;
      case ($urandom_range(0, 3))
         0: m = '0;
         1: m.ipv4_dst_addr = '1;
         2: begin
            m.ipv4_src_addr = '1;
            m.ipv4_dst_addr = '1;
            m.ip_proto = '1;
         end
         default: m = rnd_phs() & rnd_phs() & rnd_phs();
      endcase
      return mk($urandom_range(0, 4) != 0, rnd_phs(), m);
   endfunction

   function automatic PHS_Struct rnd_lookup();
      PDR_Entry e;
      if ($urandom_range(0, 2) == 0) return rnd_phs();
      e = m_tbl[$urandom_range(0, NR - 1)];
      return (e.key & e.mask) | (rnd_phs() & ~e.mask);
   endfunction

   // input side of the scoreboard: predicts with the table as it stands before this edge
   always @(negedge clk) begin
      if (rst) begin
         foreach (m_tbl[i]) m_tbl[i] = '0;
      end else begin
         if (bus.phs_valid && bus.phs_ready) sb.push_back(ref_lookup(bus.phs_in));
         if (bus.cfg_clear) foreach (m_tbl[i]) m_tbl[i].valid = 1'b0;
         if (bus.cfg_wr_en && int'(bus.cfg_wr_idx) < NR) m_tbl[bus.cfg_wr_idx] = bus.cfg_wr_entry;
      end
   end

   // output side: the head of the queue must be presented until it is taken
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         m_hit = 0;
         m_miss = 0;
      end else begin
         chk("hit_count", bus.hit_count, m_hit);
         chk("miss_count", bus.miss_count, m_miss);
         if (sb.size() == 0) chk("res_valid_idle", bus.res_valid, 0);
         else if (bus.res_valid) begin
            chk("res_hit", bus.res_hit, sb[0].hit);
            chk("res_rule_idx", bus.res_rule_idx, sb[0].idx);
            chk("res_phs", bus.res_phs, sb[0].phs);
            if (bus.res_ready) begin
               if (sb[0].hit) m_hit = m_hit < CMAX ? m_hit + 1 : CMAX;
               else m_miss = m_miss < CMAX ? m_miss + 1 : CMAX;
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input PHS_Struct p, output int waits);
      logic acc;
      acc = 1'b0;
      waits = 0;
      bus.phs_valid = 1'b1;
      bus.phs_in = p;
      #1;
      for (int k = 0; k < 100 && !acc; k++) begin
         acc = bus.phs_ready;
         if (!acc) waits++;
         tick();
      end
      bus.phs_valid = 1'b0;
      chk("send_accept", acc, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && sb.size() != 0; k++) tick();
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic wr(input int idx, input PDR_Entry e);
      bus.cfg_wr_en = 1'b1;
      bus.cfg_wr_idx = IW'(idx);
      bus.cfg_wr_entry = e;
      tick();
      bus.cfg_wr_en = 1'b0;
   endtask

   task automatic clr();
      bus.cfg_clear = 1'b1;
      tick();
      bus.cfg_clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      PHS_Struct p, p2, k, m;
      PHS_Struct ps [3];
      int w, wsum, n_acc;
      logic a;
      bus.phs_valid = 1'b0;
      bus.phs_in = '0;
      bus.cfg_wr_en = 1'b0;
      bus.cfg_wr_idx = '0;
      bus.cfg_wr_entry = '0;
      bus.cfg_clear = 1'b0;
      bus.res_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_hit", bus.res_hit, 0);
      chk("rst_res_idx", bus.res_rule_idx, 0);
      chk("rst_res_phs", bus.res_phs, 0);
      chk("rst_phs_ready", bus.phs_ready, 1);

      p = rnd_phs();
      p.ipv4_dst_addr = 32'h0A00_0001;
      k = '0;
      k.ipv4_dst_addr = 32'h0A00_0001;
      m = '0;
      m.ipv4_dst_addr = '1;
      wr(3, mk(1'b1, k, m));
      send(p, w);
      chk("t1_not_yet", bus.res_valid, 0);
      tick();
      chk("t1_res_valid", bus.res_valid, 1);
      chk("t1_hit", bus.res_hit, 1);
      chk("t1_idx", bus.res_rule_idx, 3);
      tick();
      chk("t1_hit_count", bus.hit_count, 1);
      p2 = p;
      p2.ipv4_dst_addr[0] = 1'b0;
      send(p2, w);
      drain();

      clr();
      wr(2, mk(1'b1, rnd_phs(), '0));
      wr(5, mk(1'b1, rnd_phs(), '0));
      for (int i = 0; i < 4; i++) send(rnd_phs(), w);
      drain();
      wr(2, mk(1'b0, rnd_phs(), '0));
      send(rnd_phs(), w);
      tick();
      chk("wild_hit", bus.res_hit, 1);
      chk("wild_idx5", bus.res_rule_idx, 5);
      drain();

      clr();
      wsum = 0;
      for (int i = 0; i < 4; i++) begin
         send(rnd_phs(), w);
         wsum += w;
      end
      chk("b2b_no_stall", wsum, 0);
      drain();
      chk("b2b_miss_count", bus.miss_count, 5);

      bus.res_ready = 1'b0;
      foreach (ps[i]) ps[i] = rnd_phs();
      n_acc = 0;
      #1;
      for (int c = 0; c < 5; c++) begin
         bus.phs_valid = 1'b1;
         bus.phs_in = ps[n_acc < 3 ? n_acc : 2];
         a = bus.phs_ready;
         tick();
         if (a) n_acc++;
      end
      bus.phs_valid = 1'b0;
      chk("stall_accepted", n_acc, 2);
      chk("stall_phs_ready", bus.phs_ready, 0);
      chk("stall_res_phs", bus.res_phs, ps[0]);
      bus.res_ready = 1'b1;
      for (int i = n_acc; i < 3; i++) send(ps[i], w);
      drain();

      clr();
      p = rnd_phs();
      bus.cfg_wr_en = 1'b1;
      bus.cfg_wr_idx = IW'(1);
      bus.cfg_wr_entry = mk(1'b1, p, '1);
      bus.phs_valid = 1'b1;
      bus.phs_in = p;
      a = bus.phs_ready;
      tick();
      bus.cfg_wr_en = 1'b0;
      bus.phs_valid = 1'b0;
      chk("same_cyc_accept", a, 1);
      tick();
      chk("same_cyc_valid", bus.res_valid, 1);
      chk("same_cyc_miss", bus.res_hit, 0);
      send(p, w);
      tick();
      chk("after_wr_hit", bus.res_hit, 1);
      chk("after_wr_idx", bus.res_rule_idx, 1);
      drain();
      bus.cfg_clear = 1'b1;
      bus.cfg_wr_en = 1'b1;
      bus.cfg_wr_idx = IW'(4);
      bus.cfg_wr_entry = mk(1'b1, rnd_phs(), '0);
      tick();
      bus.cfg_clear = 1'b0;
      bus.cfg_wr_en = 1'b0;
      send(p, w);
      tick();
      chk("clr_wr_hit", bus.res_hit, 1);
      chk("clr_wr_idx4", bus.res_rule_idx, 4);
      drain();

      bus.res_ready = 1'b0;
      send(rnd_phs(), w);
      send(rnd_phs(), w);
      chk("full_res_valid", bus.res_valid, 1);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", bus.res_valid, 0);
      chk("mid_rst_hits", bus.hit_count, 0);
      chk("mid_rst_miss", bus.miss_count, 0);
      rst = 1'b0;
      bus.res_ready = 1'b1;
      send(p, w);
      tick();
      chk("mid_rst_tbl_empty", bus.res_hit, 0);
      drain();

      for (int c = 0; c < 400; c++) begin
         bus.res_ready = $urandom_range(0, 3) != 0;
         bus.cfg_clear = $urandom_range(0, 60) == 0;
         bus.cfg_wr_en = $urandom_range(0, 5) == 0;
         if (bus.cfg_wr_en) begin
            bus.cfg_wr_idx = IW'($urandom_range(0, NR - 1));
            bus.cfg_wr_entry = rnd_entry();
         end
         if (!bus.phs_valid && $urandom_range(0, 2) != 0) begin
            bus.phs_valid = 1'b1;
            bus.phs_in = rnd_lookup();
         end
         #1;
         a = bus.phs_valid && bus.phs_ready;
         tick();
         if (a) bus.phs_valid = 1'b0;
      end
      bus.cfg_wr_en = 1'b0;
      bus.cfg_clear = 1'b0;
      bus.phs_valid = 1'b0;
      bus.res_ready = 1'b1;
      drain();

      rst = 1'b1;
      tick();
      rst = 1'b0;
      wr(0, mk(1'b1, rnd_phs(), '0));
      for (int i = 0; i < CMAX + 9; i++) send(rnd_phs(), w);
      drain();
      chk("sat_hit_count", bus.hit_count, CMAX);
      chk("sat_miss_zero", bus.miss_count, 0);
      clr();
      send(rnd_phs(), w);
      drain();
      chk("sat_then_miss", bus.miss_count, 1);
      chk("sat_hit_hold", bus.hit_count, CMAX);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/phs_pdr_matcher.md
Name: phs_pdr_matcher

Overview:
- Downstream consumer of the N3 parser output.
- Takes one extracted PHS_Struct per packet and matches it against a programmable table of NUM_RULES masked packet-detection rules (PDRs).
- Returns the lowest-index matching rule, or a miss, together with the original PHS.
- Two-stage pipeline with valid/ready on both sides; feeds the downstream QoS/forwarding action stage.

Parameters:
- NUM_RULES, 16, number of PDR table entries (2..64).
- IDX_W, $clog2(NUM_RULES), width of rule index fields.
- CNT_W, 32, width of the hit and miss statistics counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- phs_valid  in  1  input PHS valid.
- phs_ready  out  1  input accepted when phs_valid && phs_ready.
- phs_in  in  120 (PHS_Struct)  parsed header summary.
- cfg_wr_en  in  1  write one table entry this cycle.
- cfg_wr_idx  in  IDX_W  entry index.
- cfg_wr_entry  in  241 (PDR_Entry)  {valid, key[119:0], mask[119:0]}.
- cfg_clear  in  1  invalidate all entries.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_hit  out  1  at least one rule matched.
- res_rule_idx  out  IDX_W  lowest matching index; 0 on miss.
- res_phs  out  120  PHS passed through unchanged.
- hit_count  out  CNT_W  results delivered with hit=1.
- miss_count  out  CNT_W  results delivered with hit=0.

Behaviour:
- Reset: v1=v2=0, res_valid=0, res_hit=0, res_rule_idx=0, res_phs=0, both counters 0, all table entries fully zeroed (valid=0).
- Rule match (combinational): match[i] = entry[i].valid && (((phs_in ^ entry[i].key) & entry[i].mask) == 0). Mask bit 1 means "compare this bit".
  - A valid entry with mask=0 is a wildcard and matches everything.
- Stage 1: on input handshake, register phs_in and the NUM_RULES-bit match vector; v1 <= 1.
- Stage 2: priority-encode the stage-1 vector (lowest index wins); register hit, idx and phs into res_*; v2 <= 1.
- Flow control:
  - en2 = !v2 || res_ready.
  - en1 = !v1 || en2.
  - phs_ready = en1.
  - Stage 1 moves into stage 2 when v1 && en2.
  - v1 clears when stage 1 empties with no new input.
  - v2 clears when res_ready is high and v1=0.
- Latency: 2 cycles from input handshake to res_valid. Throughput: 1 result per cycle with res_ready held high.
- res_* outputs stay stable while res_valid && !res_ready.
- Config timing:
  - A write updates the entry at the next edge.
  - A lookup accepted in the same cycle as a write uses the pre-write table.
  - In-flight results are unaffected by later writes, because the match vector is captured at stage 1.
- cfg_clear: all valid bits go to 0 at the next edge. If cfg_clear and cfg_wr_en are asserted together, the write wins for its index.
- cfg_wr_idx >= NUM_RULES: the write is ignored.
- Counters increment on res_valid && res_ready according to res_hit. They saturate at all-ones with no wrap and clear only on rst.
- rst mid-packet: in-flight data is discarded, no result is emitted, and the table is cleared.

Decomposition:
- Add to parser_typedefs_pkg:
  - PHS_W = $bits(PHS_Struct).
  - typedef PDR_Entry packed {valid; key[PHS_W-1:0]; mask[PHS_W-1:0]}.
  - Result struct PDR_Result {hit; rule_idx; PHS_Struct phs}.
- Sub-module pdr_prio_enc: parameterised lowest-index-first priority encoder (vector in, hit plus index out), purely combinational.
- Table storage is registers, not RAM: all entries are read in parallel.

Test Plan:
- Write entry 3 = {valid, key.ipv4_dst_addr=0x0A000001, mask on dst addr only}; send PHS with dst 0x0A000001 → res_valid 2 cycles later, hit=1, idx=3, hit_count=1.
- Entries 2 and 5 both wildcard (mask=0, valid) → every PHS yields idx=2. Clear entry 2 → idx=5.
- Empty table, 4 back-to-back PHS, res_ready=1 → 4 consecutive results, all hit=0, idx=0, miss_count=4, phs_ready never drops.
- res_ready=0 for 5 cycles while 3 inputs are offered → only 2 accepted (phs_ready falls), res_* held stable. Release → results in input order, no loss or duplication.
- Write entry 1 and present a matching lookup in the same cycle → that lookup misses; the next identical lookup hits idx=1. cfg_clear with simultaneous write to idx 4 → only entry 4 valid afterwards.
- Preload counters near all-ones (force), deliver hits → hit_count stays 0xFFFFFFFF. Assert rst with both stages full → res_valid=0 next cycle, table empty, counters 0.
